// File: rtl/bubble_sort_ctrl_if.sv
// bubble_sort_ctrl_if
// Bundles the array-load/start/pacing inputs and the renderer-facing outputs
// of the animated bubble-sort sequencer.
//   master : switch logic + pixel renderer side (drives load/start/step_tick)
//   slave  : bubble_sort_ctrl side (drives heights and the compare/swap markers)
// Packing of load_data/heights: element i at bits [i*W +: W], index 0 leftmost.
interface bubble_sort_ctrl_if #(
  parameter int N = 5,
  parameter int W = 7
);
  logic           load;
  logic [N*W-1:0] load_data;
  logic           start;
  logic           step_tick;
  logic [N*W-1:0] heights;
  logic [2:0]     cmp_idx;
  logic           cmp_valid;
  logic           swapping;
  logic           busy;
  logic           done;

  modport master (
    output load, load_data, start, step_tick,
    input  heights, cmp_idx, cmp_valid, swapping, busy, done
  );

  modport slave (
    input  load, load_data, start, step_tick,
    output heights, cmp_idx, cmp_valid, swapping, busy, done
  );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl
// Owns the bar-height array for the bar-chart view and runs a bubble sort on
// it, one compare or one swap per step_tick, so each step can be animated.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : bubble_sort_ctrl_if.slave
//           in  load, load_data[N*W], start, step_tick
//           out heights[N*W], cmp_idx[3], cmp_valid, swapping, busy, done
// All outputs come from registered state only.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | array held, waiting for load/start
// COMPARE | pair (j, j+1) shown; next tick decides swap or advance
// SWAP    | pair (j, j+1) out of order; next tick exchanges and advances
// DONE    | sort finished, array held until load/start
module bubble_sort_ctrl #(
  parameter int N = 5,
  parameter int W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  bubble_sort_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_SWAP    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   arr_q [N];
  logic [W-1:0]   arr_d [N];
  logic [2:0]     j_q, j_d;
  logic [2:0]     pass_q, pass_d;
  logic           swp_q, swp_d;

  logic [W-1:0]   a_lo, a_hi;
  logic           last_in_pass;
  logic           do_adv;
  logic           any_swap;
  logic [N*W-1:0] heights_w;

  // Pair under compare, selected by loop compare rather than a dynamic index
  // so the mux stays in range for every legal N.
  always_comb begin
    a_lo = '0;
    a_hi = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (j_q == 3'(i)) begin
        a_lo = arr_q[i];
        a_hi = arr_q[i+1];
      end
    end
  end

  // Pass shrinks by one each time: the largest remaining element has bubbled
  // to position N-1-pass.
  assign last_in_pass = !((int'(j_q) + 1) < (N - 1 - int'(pass_q)));

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    pass_d   = pass_q;
    swp_d    = swp_q;
    arr_d    = arr_q;
    do_adv   = 1'b0;
    any_swap = swp_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // load has priority; a simultaneous start is dropped
        if (bus.load) begin
          for (int i = 0; i < N; i++) begin
            arr_d[i] = bus.load_data[i*W +: W];
          end
          state_d = S_IDLE;
          j_d     = '0;
          pass_d  = '0;
        end else if (bus.start) begin
          state_d = S_COMPARE;
          j_d     = '0;
          pass_d  = '0;
          swp_d   = 1'b0;
        end
      end

      S_COMPARE: begin
        if (bus.step_tick) begin
          // strict compare keeps equal elements in place (stable sort)
          if (a_lo > a_hi) begin
            state_d = S_SWAP;
          end else begin
            do_adv = 1'b1;
          end
        end
      end

      S_SWAP: begin
        if (bus.step_tick) begin
          for (int i = 0; i < N - 1; i++) begin
            if (j_q == 3'(i)) begin
              arr_d[i]   = a_hi;
              arr_d[i+1] = a_lo;
            end
          end
          swp_d    = 1'b1;
          any_swap = 1'b1;
          do_adv   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (do_adv) begin
      if (!last_in_pass) begin
        j_d     = j_q + 3'd1;
        state_d = S_COMPARE;
      end else if (!any_swap || (int'(pass_q) + 1 == N - 1)) begin
        // j intentionally left alone so cmp_idx keeps the final pair
        state_d = S_DONE;
      end else begin
        pass_d  = pass_q + 3'd1;
        j_d     = '0;
        swp_d   = 1'b0;
        state_d = S_COMPARE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      pass_q  <= '0;
      swp_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      pass_q  <= pass_d;
      swp_q   <= swp_d;
      for (int i = 0; i < N; i++) begin
        arr_q[i] <= arr_d[i];
      end
    end
  end

  always_comb begin
    heights_w = '0;
    for (int i = 0; i < N; i++) begin
      heights_w[i*W +: W] = arr_q[i];
    end
  end

  assign bus.heights   = heights_w;
  assign bus.cmp_idx   = j_q;
  assign bus.cmp_valid = (state_q == S_COMPARE) || (state_q == S_SWAP);
  assign bus.busy      = (state_q == S_COMPARE) || (state_q == S_SWAP);
  assign bus.swapping  = (state_q == S_SWAP);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
module tb_bubble_sort_ctrl;
  localparam int N = 5;
  localparam int W = 7;
  typedef logic [N*W-1:0] vec_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // reference event list: one entry per step_tick the sort consumes
  int   ev_j  [$];
  bit   ev_sw [$];
  vec_t ev_h  [$];

  bubble_sort_ctrl_if #(.N(N), .W(W)) bus ();

  bubble_sort_ctrl #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t pack(input int a [N]);
    vec_t v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(a[i]);
    return v;
  endfunction

  function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3, input int e4);
    int a [N];
    a[0] = e0; a[1] = e1; a[2] = e2; a[3] = e3; a[4] = e4;
    return pack(a);
  endfunction

  // Plain early-exit bubble sort: each compare is one tick, each swap one more.
  task automatic build_model(input vec_t d);
    int a [N];
    int pass;
    int t;
    bit swapped;
    ev_j.delete(); ev_sw.delete(); ev_h.delete();
    for (int i = 0; i < N; i++) a[i] = int'(d[i*W +: W]);
    pass = 0;
    forever begin
      swapped = 0;
      for (int j = 0; j < N - 1 - pass; j++) begin
        if (a[j] > a[j+1]) begin
          ev_j.push_back(j); ev_sw.push_back(0); ev_h.push_back(pack(a));
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          swapped = 1;
          ev_j.push_back(j); ev_sw.push_back(1); ev_h.push_back(pack(a));
        end else begin
          ev_j.push_back(j); ev_sw.push_back(0); ev_h.push_back(pack(a));
        end
      end
      pass++;
      if (!swapped || pass == N - 1) break;
    end
  endtask

  task automatic load_vec(input vec_t d);
    bus.load = 1'b1; bus.load_data = d;
    cyc();
    bus.load = 1'b0;
    chk("load_heights", bus.heights, d);
    chk("load_busy", bus.busy, 1'b0);
    chk("load_done", bus.done, 1'b0);
  endtask

  // gap: cycles per tick; freeze_at/poke_at: event index for a 100-cycle stall
  // or a busy load+start attempt (-1 = none); abort: reset at first SWAP;
  // exp_swaps: required swap count (-1 = don't care).
  task automatic run_sort(input string name, input vec_t d, input int gap,
                          input bit tick_with_start, input int freeze_at,
                          input int poke_at, input bit abort, input int exp_swaps);
    vec_t cur;
    int   nsw;
    load_vec(d);
    build_model(d);
    bus.start = 1'b1; bus.step_tick = tick_with_start;
    cyc();
    bus.start = 1'b0; bus.step_tick = 1'b0;
    chk({name, "_start_busy"}, bus.busy, 1'b1);
    chk({name, "_start_heights"}, bus.heights, d);
    cur = d;
    nsw = 0;
    for (int k = 0; k < ev_j.size(); k++) begin
      if (k == freeze_at) begin
        repeat (100) cyc();
        chk({name, "_freeze_heights"}, bus.heights, cur);
        chk({name, "_freeze_idx"}, bus.cmp_idx, ev_j[k]);
        chk({name, "_freeze_swap"}, bus.swapping, ev_sw[k]);
        chk({name, "_freeze_busy"}, bus.busy, 1'b1);
      end
      if (k == poke_at) begin
        bus.load = 1'b1; bus.load_data = ~d; bus.start = 1'b1;
        cyc();
        bus.load = 1'b0; bus.start = 1'b0;
        chk({name, "_poke_heights"}, bus.heights, cur);
        chk({name, "_poke_idx"}, bus.cmp_idx, ev_j[k]);
        chk({name, "_poke_swap"}, bus.swapping, ev_sw[k]);
      end
      repeat (gap - 1) cyc();
      chk({name, "_pre_idx"}, bus.cmp_idx, ev_j[k]);
      chk({name, "_pre_swap"}, bus.swapping, ev_sw[k]);
      chk({name, "_pre_valid"}, bus.cmp_valid, 1'b1);
      chk({name, "_pre_done"}, bus.done, 1'b0);
      if (bus.swapping === 1'b1) nsw++;
      if (abort && ev_sw[k]) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk({name, "_rst_heights"}, bus.heights, '0);
        chk({name, "_rst_idx"}, bus.cmp_idx, 3'd0);
        chk({name, "_rst_flags"}, {bus.cmp_valid, bus.swapping, bus.busy, bus.done}, 4'b0000);
        bus.step_tick = 1'b1;
        cyc();
        bus.step_tick = 1'b0;
        chk({name, "_rst_stays_idle"}, {bus.busy, bus.done}, 2'b00);
        return;
      end
      bus.step_tick = 1'b1;
      cyc();
      bus.step_tick = 1'b0;
      cur = ev_h[k];
      chk({name, "_post_heights"}, bus.heights, cur);
    end
    chk({name, "_end_done"}, bus.done, 1'b1);
    chk({name, "_end_busy"}, bus.busy, 1'b0);
    chk({name, "_end_valid"}, bus.cmp_valid, 1'b0);
    chk({name, "_end_idx_held"}, bus.cmp_idx, ev_j[ev_j.size()-1]);
    repeat (3) cyc();
    chk({name, "_done_hold"}, bus.heights, cur);
    if (exp_swaps >= 0) chk({name, "_swap_count"}, nsw, exp_swaps);
  endtask

  initial begin
    vec_t d;
    reset = 1'b1;
    bus.load = 1'b0; bus.load_data = '0; bus.start = 1'b0; bus.step_tick = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset_heights", bus.heights, '0);
    chk("reset_idx", bus.cmp_idx, 3'd0);
    chk("reset_flags", {bus.cmp_valid, bus.swapping, bus.busy, bus.done}, 4'b0000);

    // directed cases
    run_sort("mixed",    mk(30, 10, 20, 50, 40), 4, 0, -1, -1, 0, 3);
    chk("mixed_sorted", bus.heights, mk(10, 20, 30, 40, 50));
    chk("mixed_ticks", ev_j.size(), 10);
    run_sort("reverse",  mk(50, 40, 30, 20, 10), 1, 1, 7, -1, 0, 10);
    chk("reverse_sorted", bus.heights, mk(10, 20, 30, 40, 50));
    run_sort("sorted",   mk(10, 20, 30, 40, 50), 2, 1, -1, -1, 0, 0);
    run_sort("equal",    mk(7, 7, 7, 7, 7),      1, 0, -1, 2, 0, 0);

    // load and start together in DONE: load wins, state returns to IDLE
    d = mk(3, 1, 2, 5, 4);
    bus.load = 1'b1; bus.start = 1'b1; bus.load_data = d;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    chk("ls_heights", bus.heights, d);
    chk("ls_idle", {bus.busy, bus.done, bus.cmp_valid}, 3'b000);
    chk("ls_idx", bus.cmp_idx, 3'd0);
    bus.step_tick = 1'b1;
    repeat (3) cyc();
    bus.step_tick = 1'b0;
    chk("ls_still_idle", bus.heights, d);

    // randomized arrays, some with many duplicates
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        d[i*W +: W] = W'((r % 2 == 0) ? $urandom_range(0, (1 << W) - 1) : $urandom_range(0, 3));
      run_sort("rand", d, 1 + (r % 3), r[0], (r == 3) ? 2 : -1, (r == 5) ? 1 : -1, 0, -1);
    end

    // reset while in SWAP
    run_sort("abort", mk(50, 40, 30, 20, 10), 2, 0, -1, -1, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
